control_sequencer: RTL

Multi-cycle control unit for the MIPS datapath. It holds the 7-bit control state register and walks each instruction through fetch, decode and execute. At decode it jumps to the execute state number supplied by the instruction state encoder. Every datapath control line is driven from the current state, and the memory handshake waits on MOC.

---
 rtl/control_sequencer_pkg.sv | 64 ++++++
 rtl/control_sequencer_if.sv | 38 +++
 rtl/control_sequencer_rom.sv | 72 +++++++
 rtl/control_sequencer.sv | 99 +++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the multi-cycle MIPS control sequencer:
// state numbers, ALU operation codes and the packed control word.
package control_pkg;

    typedef enum logic [6:0] {
        S_RESET      = 7'd0,
        S_FETCH      = 7'd1,
        S_FETCH_WAIT = 7'd2,
        S_IR_LD      = 7'd3,
        S_DECODE     = 7'd4,
        S_ADDU       = 7'd6,
        S_ST_ADDR    = 7'd7,
        S_ST_MDR     = 7'd8,
        S_ST_WAIT    = 7'd9,
        S_BEQ        = 7'd11,
        S_BEQ_TAKE   = 7'd12,
        S_LD_ADDR    = 7'd13,
        S_LD_WAIT    = 7'd14,
        S_LD_WB      = 7'd15,
        S_SUBU       = 7'd17,
        S_ADDIU      = 7'd18,
        S_SLTU       = 7'd19,
        S_SLTIU      = 7'd20,
        S_CLO        = 7'd21,
        S_CLZ        = 7'd22,
        S_AND        = 7'd23
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLTU = 4'd2,
        ALU_CLO  = 4'd3,
        ALU_CLZ  = 4'd4,
        ALU_AND  = 4'd5
    } alu_op_t;

    typedef struct packed {
        logic    mar_ld;
        logic    mdr_ld;
        logic    ir_ld;
        logic    pc_ld;
        logic    rf_ld;
        logic    mdr_src;
        logic    pc_src;
        logic    rf_dst;
        logic    rf_src;
        logic    alu_src_b;
        alu_op_t alu_op;
        logic    mem_en;
        logic    mem_rw;
    } ctrl_word_t;

    // True for the execute states the decoder is allowed to jump to
    function automatic logic is_exec_state(input logic [6:0] sel);
        case (sel)
            7'd6, 7'd7, 7'd11, 7'd13,
            7'd17, 7'd18, 7'd19, 7'd20,
            7'd21, 7'd22, 7'd23: is_exec_state = 1'b1;
            default:             is_exec_state = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle of the sequencer's datapath-facing signals. The sequencer uses
// the master view; the datapath (or a bench) uses the slave view.
interface control_sequencer_if;
    logic [6:0] state_sel;
    logic       moc;
    logic       alu_zero;

    logic [6:0] state;
    logic       mar_ld;
    logic       mdr_ld;
    logic       ir_ld;
    logic       pc_ld;
    logic       rf_ld;
    logic       mdr_src;
    logic       pc_src;
    logic       rf_dst;
    logic       rf_src;
    logic       alu_src_b;
    logic [3:0] alu_op;
    logic       mem_en;
    logic       mem_rw;
    logic       illegal;
    logic       bus_err;

    modport master (
        input  state_sel, moc, alu_zero,
        output state, mar_ld, mdr_ld, ir_ld, pc_ld, rf_ld,
               mdr_src, pc_src, rf_dst, rf_src, alu_src_b, alu_op,
               mem_en, mem_rw, illegal, bus_err
    );

    modport slave (
        output state_sel, moc, alu_zero,
        input  state, mar_ld, mdr_ld, ir_ld, pc_ld, rf_ld,
               mdr_src, pc_src, rf_dst, rf_src, alu_src_b, alu_op,
               mem_en, mem_rw, illegal, bus_err
    );
endinterface

// File: rtl/control_sequencer_rom.sv
// Combinational decode of the current state into the Moore control word.
// The moc-dependent MDR load in memory-read wait states is added by the
// sequencer, so those states carry mdr_ld=0 here.
module control_rom
    import control_pkg::*;
(
    input  state_t     state_i,
    output ctrl_word_t ctrl_o
);

    // Every field defaults to 0 and each state only raises what it needs
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mar_ld = 1'b1;
            end
            S_FETCH_WAIT, S_LD_WAIT: begin
                ctrl_o.mem_en = 1'b1;
            end
            S_IR_LD: begin
                ctrl_o.ir_ld = 1'b1;
                ctrl_o.pc_ld = 1'b1;
            end
            S_ADDU, S_SUBU, S_SLTU, S_CLO, S_CLZ, S_AND: begin
                ctrl_o.rf_ld = 1'b1;
                case (state_i)
                    S_SUBU:  ctrl_o.alu_op = ALU_SUB;
                    S_SLTU:  ctrl_o.alu_op = ALU_SLTU;
                    S_CLO:   ctrl_o.alu_op = ALU_CLO;
                    S_CLZ:   ctrl_o.alu_op = ALU_CLZ;
                    S_AND:   ctrl_o.alu_op = ALU_AND;
                    default: ctrl_o.alu_op = ALU_ADD;
                endcase
            end
            S_ADDIU, S_SLTIU: begin
                ctrl_o.rf_ld     = 1'b1;
                ctrl_o.rf_dst    = 1'b1;
                ctrl_o.alu_src_b = 1'b1;
                ctrl_o.alu_op    = (state_i == S_SLTIU) ? ALU_SLTU : ALU_ADD;
            end
            S_ST_ADDR, S_LD_ADDR: begin
                ctrl_o.mar_ld    = 1'b1;
                ctrl_o.alu_src_b = 1'b1;
            end
            S_ST_MDR: begin
                ctrl_o.mdr_ld  = 1'b1;
                ctrl_o.mdr_src = 1'b1;
            end
            S_ST_WAIT: begin
                ctrl_o.mem_en = 1'b1;
                ctrl_o.mem_rw = 1'b1;
            end
            S_BEQ: begin
                ctrl_o.alu_op = ALU_SUB;
            end
            S_BEQ_TAKE: begin
                ctrl_o.pc_ld  = 1'b1;
                ctrl_o.pc_src = 1'b1;
            end
            S_LD_WB: begin
                ctrl_o.rf_ld  = 1'b1;
                ctrl_o.rf_dst = 1'b1;
                ctrl_o.rf_src = 1'b1;
            end
            default: begin
                ctrl_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle MIPS control unit: owns the state register, next-state
// logic and the memory wait counter; the control word comes from
// control_rom. A memory wait that sees no moc for MOC_TIMEOUT cycles
// is abandoned with a one-cycle bus_err pulse.
module control_sequencer
    import control_pkg::*;
#(
    parameter int MOC_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    control_sequencer_if.master bus
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(MOC_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       in_wait;
    logic       timeout;
    logic       illegal;
    ctrl_word_t cw;

    control_rom u_rom (
        .state_i (state_q),
        .ctrl_o  (cw)
    );

    // Next state, wait-counter update and the two error pulses. The counter
    // is held at zero outside wait states so every wait entry starts fresh.
    always_comb begin
        state_d    = S_RESET;
        illegal    = 1'b0;
        in_wait    = (state_q == S_FETCH_WAIT) || (state_q == S_ST_WAIT) ||
                     (state_q == S_LD_WAIT);
        timeout    = in_wait && !bus.moc && (wait_cnt_q == TIMEOUT_LAST);
        wait_cnt_d = 8'd0;
        if (in_wait && !bus.moc) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
        case (state_q)
            S_RESET:      state_d = S_FETCH;
            S_FETCH:      state_d = S_FETCH_WAIT;
            S_FETCH_WAIT: state_d = bus.moc ? S_IR_LD :
                                    (timeout ? S_FETCH : S_FETCH_WAIT);
            S_IR_LD:      state_d = S_DECODE;
            S_DECODE: begin
                if (is_exec_state(bus.state_sel)) begin
                    state_d = state_t'(bus.state_sel);
                end else begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_ADDU, S_SUBU, S_ADDIU, S_SLTU,
            S_SLTIU, S_CLO, S_CLZ, S_AND:
                          state_d = S_FETCH;
            S_ST_ADDR:    state_d = S_ST_MDR;
            S_ST_MDR:     state_d = S_ST_WAIT;
            S_ST_WAIT:    state_d = (bus.moc || timeout) ? S_FETCH : S_ST_WAIT;
            S_BEQ:        state_d = bus.alu_zero ? S_BEQ_TAKE : S_FETCH;
            S_BEQ_TAKE:   state_d = S_FETCH;
            S_LD_ADDR:    state_d = S_LD_WAIT;
            S_LD_WAIT:    state_d = bus.moc ? S_LD_WB :
                                    (timeout ? S_FETCH : S_LD_WAIT);
            S_LD_WB:      state_d = S_FETCH;
            default:      state_d = S_RESET;
        endcase
    end

    // State register and wait counter; reset overrides everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_RESET;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.mar_ld    = cw.mar_ld;
    assign bus.mdr_ld    = cw.mdr_ld | (cw.mem_en & ~cw.mem_rw & bus.moc);
    assign bus.ir_ld     = cw.ir_ld;
    assign bus.pc_ld     = cw.pc_ld;
    assign bus.rf_ld     = cw.rf_ld;
    assign bus.mdr_src   = cw.mdr_src;
    assign bus.pc_src    = cw.pc_src;
    assign bus.rf_dst    = cw.rf_dst;
    assign bus.rf_src    = cw.rf_src;
    assign bus.alu_src_b = cw.alu_src_b;
    assign bus.alu_op    = cw.alu_op;
    assign bus.mem_en    = cw.mem_en;
    assign bus.mem_rw    = cw.mem_rw;
    assign bus.illegal   = illegal;
    assign bus.bus_err   = timeout;

endmodule
